// File: rtl/mc_datapath_regs.sv
`default_nettype none
// ============================================================================
// Module   : mc_datapath_regs
// Brief    : Multicycle CPU architectural registers, PC next-value and operand/
//            address steering driven by the main controller's control word.
// Revision : 1.0 - initial release
// ============================================================================
module mc_datapath_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             PCWriteCond,
    input  logic             IorD,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             IRWrite,
    input  logic             MemtoReg,
    input  logic             RegWrite,
    input  logic             RegDst,
    input  logic             ALUSrcA,
    input  logic [1:0]       PCSource,
    input  logic [1:0]       ALUSrcB,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic [31:0]      rf_rd1,
    input  logic [31:0]      rf_rd2,
    input  logic [31:0]      mem_rdata,
    output logic [5:0]       opcode,
    output logic [31:0]      pc,
    output logic [31:0]      ir,
    output logic [31:0]      mdr,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [31:0]      aluout,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [4:0]       rf_ra1,
    output logic [4:0]       rf_ra2,
    output logic [4:0]       rf_wa,
    output logic [31:0]      rf_wd,
    output logic             rf_we,
    output logic [CNT_W-1:0] fetch_count,
    output logic             mem_conflict
);

    localparam logic [31:0] C_FOUR = 32'd4;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [CNT_W-1:0] fcnt_q;
    logic             conflict_q;
    logic             pc_en;
    logic [31:0]      imm_sext;

    assign pc_en    = PCWrite | (PCWriteCond & alu_zero);
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    // PCSource=11 is a hold even when the PC is enabled.
    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            case (PCSource)
                2'b00:   pc_d = alu_result;
                2'b01:   pc_d = aluout_q;
                2'b10:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            mdr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            aluout_q   <= '0;
            fcnt_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            a_q      <= rf_rd1;
            b_q      <= rf_rd2;
            aluout_q <= alu_result;
            if (IRWrite) begin
                ir_q   <= mem_rdata;
                fcnt_q <= fcnt_q + CNT_W'(1);
            end
            if (MemRead) begin
                mdr_q <= mem_rdata;
            end
            if (MemRead & MemWrite) begin
                conflict_q <= 1'b1;
            end
        end
    end

    always_comb begin
        alu_b = b_q;
        case (ALUSrcB)
            2'b00:   alu_b = b_q;
            2'b01:   alu_b = C_FOUR;
            2'b10:   alu_b = imm_sext;
            default: alu_b = {imm_sext[29:0], 2'b00};
        endcase
    end

    assign alu_a        = ALUSrcA ? a_q : pc_q;
    assign mem_addr     = IorD ? aluout_q : pc_q;
    assign mem_wdata    = b_q;
    assign mem_rd       = MemRead;
    assign mem_wr       = MemWrite & ~MemRead;
    assign rf_ra1       = ir_q[25:21];
    assign rf_ra2       = ir_q[20:16];
    assign rf_wa        = RegDst ? ir_q[15:11] : ir_q[20:16];
    assign rf_wd        = MemtoReg ? mdr_q : aluout_q;
    assign rf_we        = RegWrite;

    assign opcode       = ir_q[31:26];
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign mdr          = mdr_q;
    assign a            = a_q;
    assign b            = b_q;
    assign aluout       = aluout_q;
    assign fetch_count  = fcnt_q;
    assign mem_conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_datapath_regs
// Brief    : Randomized and directed bench for mc_datapath_regs with a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_datapath_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]  PCSource, ALUSrcB;
    logic [31:0] alu_result, rf_rd1, rf_rd2, mem_rdata;
    logic        alu_zero;
    logic [5:0]  opcode;
    logic [31:0] pc, ir, mdr, a, b, aluout, alu_a, alu_b, mem_addr, mem_wdata, rf_wd;
    logic        mem_rd, mem_wr, rf_we, mem_conflict;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout, m_fc;
    logic        m_conf;

    always #5 clk = ~clk;

    mc_datapath_regs #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .mem_rdata(mem_rdata),
        .opcode(opcode), .pc(pc), .ir(ir), .mdr(mdr), .a(a), .b(b),
        .aluout(aluout), .alu_a(alu_a), .alu_b(alu_b),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .rf_we(rf_we),
        .fetch_count(fetch_count), .mem_conflict(mem_conflict)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0;
        RegWrite = 1'b0; RegDst = 1'b0; ALUSrcA = 1'b0;
        PCSource = 2'b00; ALUSrcB = 2'b00; alu_zero = 1'b0;
        alu_result = 32'h0; rf_rd1 = 32'h0; rf_rd2 = 32'h0; mem_rdata = 32'h0;
    endtask

    task automatic set_random();
        PCWrite = 1'($urandom); PCWriteCond = 1'($urandom); IorD = 1'($urandom);
        MemRead = 1'($urandom); MemWrite = ($urandom_range(0, 7) == 0);
        IRWrite = 1'($urandom); MemtoReg = 1'($urandom); RegWrite = 1'($urandom);
        RegDst = 1'($urandom); ALUSrcA = 1'($urandom);
        PCSource = 2'($urandom); ALUSrcB = 2'($urandom); alu_zero = 1'($urandom);
        alu_result = $urandom; rf_rd1 = $urandom; rf_rd2 = $urandom; mem_rdata = $urandom;
    endtask

    // Architectural meaning of one rising edge, from the current inputs.
    task automatic model_update();
        logic [31:0] npc;
        if (rst) begin
            m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
            m_fc = 0; m_conf = 1'b0;
        end else begin
            npc = m_pc;
            if (PCWrite || (PCWriteCond && alu_zero)) begin
                if (PCSource == 2'd0)      npc = alu_result;
                else if (PCSource == 2'd1) npc = m_aluout;
                else if (PCSource == 2'd2) npc = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
            end
            if (IRWrite) begin
                m_ir = mem_rdata;
                m_fc = m_fc + 1;
            end
            if (MemRead) m_mdr = mem_rdata;
            if (MemRead && MemWrite) m_conf = 1'b1;
            m_pc = npc; m_a = rf_rd1; m_b = rf_rd2; m_aluout = alu_result;
        end
    endtask

    task automatic check_regs();
        check("pc", pc, m_pc);
        check("ir", ir, m_ir);
        check("mdr", mdr, m_mdr);
        check("a", a, m_a);
        check("b", b, m_b);
        check("aluout", aluout, m_aluout);
        check("fetch_count", fetch_count, m_fc);
        check("mem_conflict", mem_conflict, m_conf);
    endtask

    task automatic check_comb();
        int signed   imm;
        logic [31:0] eb;
        imm = int'($signed(m_ir[15:0]));
        case (ALUSrcB)
            2'd0:    eb = m_b;
            2'd1:    eb = 32'd4;
            2'd2:    eb = 32'(imm);
            default: eb = 32'(imm * 4);
        endcase
        check("opcode", opcode, m_ir >> 26);
        check("alu_a", alu_a, ALUSrcA ? m_a : m_pc);
        check("alu_b", alu_b, eb);
        check("mem_addr", mem_addr, IorD ? m_aluout : m_pc);
        check("mem_wdata", mem_wdata, m_b);
        check("mem_rd", mem_rd, MemRead);
        check("mem_wr", mem_wr, MemWrite && !MemRead);
        check("rf_ra1", rf_ra1, (m_ir >> 21) % 32);
        check("rf_ra2", rf_ra2, (m_ir >> 16) % 32);
        check("rf_wa", rf_wa, RegDst ? (m_ir >> 11) % 32 : (m_ir >> 16) % 32);
        check("rf_wd", rf_wd, MemtoReg ? m_mdr : m_aluout);
        check("rf_we", rf_we, RegWrite);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_regs();
    endtask

    initial begin
        set_idle();
        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_random();
            rst = 1'b1;
            step();
        end
        check("rst_pc", pc, 32'h0);
        check("rst_opcode", opcode, 6'h0);
        @(negedge clk);
        set_idle();
        #1;
        check("rst_mem_addr", mem_addr, 32'h0);
        check_comb();

        // Fetch
        MemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b00;
        alu_result = 32'd4; mem_rdata = 32'h8C22_0004;
        step();
        check("fetch_ir", ir, 32'h8C22_0004);
        check("fetch_opcode", opcode, 6'h23);
        check("fetch_pc", pc, 32'd4);
        check("fetch_cnt", fetch_count, 32'd1);
        check("fetch_ra1", rf_ra1, 5'd1);
        check("fetch_ra2", rf_ra2, 5'd2);

        // Branch taken, then branch not taken
        @(negedge clk); set_idle(); alu_result = 32'h40; #1; check_comb(); step();
        @(negedge clk); set_idle(); PCWriteCond = 1'b1; PCSource = 2'b01; alu_zero = 1'b1;
        alu_result = 32'h80; #1; check_comb(); step();
        check("br_taken_pc", pc, 32'h40);
        @(negedge clk); set_idle(); PCWriteCond = 1'b1; PCSource = 2'b01; alu_zero = 1'b0;
        alu_result = 32'h80; #1; check_comb(); step();
        check("br_not_taken_pc", pc, 32'h40);

        // Jump
        @(negedge clk); set_idle(); PCWrite = 1'b1; alu_result = 32'h1000_0004;
        IRWrite = 1'b1; mem_rdata = 32'h0800_0010; step();
        @(negedge clk); set_idle(); PCWrite = 1'b1; PCSource = 2'b10; #1; check_comb(); step();
        check("jump_pc", pc, 32'h1000_0040);

        // Negative immediate
        @(negedge clk); set_idle(); IRWrite = 1'b1; mem_rdata = 32'h0000_FFFC; step();
        @(negedge clk); set_idle(); ALUSrcB = 2'b10; #1;
        check("imm_sext", alu_b, 32'hFFFF_FFFC);
        ALUSrcB = 2'b11; #1;
        check("imm_sext_sh2", alu_b, 32'hFFFF_FFF0);
        step();

        // Memory conflict is sticky until reset
        @(negedge clk); set_idle(); MemRead = 1'b1; MemWrite = 1'b1; #1;
        check("conflict_wr", mem_wr, 1'b0);
        step();
        check("conflict_set", mem_conflict, 1'b1);
        @(negedge clk); set_idle(); step();
        check("conflict_sticky", mem_conflict, 1'b1);
        @(negedge clk); set_idle(); rst = 1'b1; step();
        check("conflict_clr", mem_conflict, 1'b0);

        // Advance some state, then reset on a fetch edge
        @(negedge clk); set_idle(); IRWrite = 1'b1; PCWrite = 1'b1; alu_result = 32'h8;
        mem_rdata = 32'h1234_5678; step();
        @(negedge clk); set_idle(); rst = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1;
        alu_result = 32'h0C; mem_rdata = 32'hDEAD_BEEF; step();
        check("rstmid_pc", pc, 32'h0);
        check("rstmid_ir", ir, 32'h0);
        check("rstmid_cnt", fetch_count, 32'h0);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_random();
            rst = ($urandom_range(0, 49) == 0);
            #1;
            check_comb();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
